// File: rtl/m68k_irq_ctrl_if.sv
// m68k_irq_ctrl_if: 68K bus signals seen by the interrupt controller
interface m68k_irq_ctrl_if;
  logic        cpu_as_n;
  logic        cpu_rw;
  logic        cpu_lds_n;
  logic [2:0]  cpu_fc;
  logic [2:0]  cpu_a;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic [2:0]  cpu_ipl_n;
  modport master (
    output cpu_as_n, cpu_rw, cpu_lds_n, cpu_fc, cpu_a, cpu_din,
    input  cpu_dout, cpu_ipl_n
  );
  modport slave (
    input  cpu_as_n, cpu_rw, cpu_lds_n, cpu_fc, cpu_a, cpu_din,
    output cpu_dout, cpu_ipl_n
  );
endinterface

// File: rtl/m68k_irq_ctrl.sv
// m68k_irq_ctrl: vblank autovector IRQ, interrupt-enable and Z80-reset registers for a 68K host
module m68k_irq_ctrl #(
  parameter int IRQ_LEVEL    = 4,
  parameter bit Z80_RST_INIT = 1'b0,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  m68k_irq_ctrl_if.slave  bus,
  input  logic            int_en_cs,
  input  logic            vblank_cs,
  input  logic            frame_done_cs,
  input  logic            reset_z80_cs,
  input  logic            vblank_in,
  output logic            int_en,
  output logic            irq_pending,
  output logic            frame_done,
  output logic            z80_reset_n
);
  localparam logic [2:0] LVL = 3'(IRQ_LEVEL);
  // S_ARM: out of reset, waiting to see AS high so a cycle already in flight is never acted on
  typedef enum logic [1:0] {S_ARM, S_IDLE, S_BUSY} bus_state_t;
  bus_state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sync;
  logic vbl_s, vbl_s_d, rise, act, wr, en_wr, en_nx, iack, pend_nx;
  logic unused_din;
  assign unused_din = ^bus.cpu_din[15:1];
  assign vbl_s   = sync[SYNC_STAGES-1];
  assign rise    = vbl_s & ~vbl_s_d;
  assign wr      = act & ~bus.cpu_rw & ~bus.cpu_lds_n;
  assign en_wr   = wr & int_en_cs;
  assign en_nx   = en_wr ? bus.cpu_din[0] : int_en;
  assign iack    = act && bus.cpu_fc == 3'b111 && bus.cpu_a == LVL;
  assign pend_nx = (en_wr && !bus.cpu_din[0]) ? 1'b0 : (rise && en_nx) ? 1'b1 : iack ? 1'b0 : irq_pending;
  // bus-cycle tracker state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= S_ARM;
    else state <= state_nx;
  // one action clock per AS assertion
  always_comb begin
    state_nx = bus.cpu_as_n ? S_IDLE : (state == S_ARM ? S_ARM : S_BUSY);
    act      = !bus.cpu_as_n && state == S_IDLE;
  end
  // vblank synchroniser and edge-detect history
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sync    <= '0;
      vbl_s_d <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], vblank_in};
      vbl_s_d <= vbl_s;
    end
  // CPU-visible registers, IRQ latch and registered IPL
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      bus.cpu_dout  <= '0;
      bus.cpu_ipl_n <= 3'b111;
      int_en        <= 1'b0;
      irq_pending   <= 1'b0;
      frame_done    <= 1'b0;
      z80_reset_n   <= Z80_RST_INIT;
    end else begin
      bus.cpu_dout  <= (act && bus.cpu_rw && vblank_cs) ? {15'b0, vbl_s} : bus.cpu_dout;
      bus.cpu_ipl_n <= irq_pending ? ~LVL : 3'b111;
      int_en        <= en_nx;
      irq_pending   <= pend_nx;
      frame_done    <= wr & frame_done_cs;
      z80_reset_n   <= (wr && reset_z80_cs) ? bus.cpu_din[0] : z80_reset_n;
    end
endmodule
